// File: rtl/bus_ram_ctrl_if.sv
// Handshake and control signals between the processor bus master and bus_ram_ctrl.
interface bus_ram_ctrl_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              req;
    logic              rwn;
    logic [ADDR_W-1:0] addr;
    logic              clr;
    logic              ack;
    logic              drive_en;
    logic              busy;

    modport master (
        output req, rwn, addr, clr,
        input  ack, drive_en, busy
    );

    modport slave (
        input  req, rwn, addr, clr,
        output ack, drive_en, busy
    );
endinterface

// File: rtl/bus_ram_ctrl.sv
// Clocked single-port RAM on a shared tri-state data bus, with a sampled
// request/acknowledge handshake, a mandatory turnaround cycle after every read
// and a hardware clear sweep. The data bus stays a plain module-level net so
// that its tri-state drivers resolve at the boundary.
module bus_ram_ctrl #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 8,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_ram_ctrl_if.slave     bus,
    inout  wire  [DATA_W-1:0] data
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_DRV  = 3'd2;
    localparam logic [2:0] S_TURN = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_CLR  = 3'd5;

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic              clr_pend_q, clr_pend_d;
    logic              ack_q,      ack_d;
    logic              drive_en_q, drive_en_d;
    logic              busy_q,     busy_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Next-state, memory write port and registered output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        clr_pend_d  = clr_pend_q;
        rdata_d     = rdata_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_q;
        mem_wdata_c = data;

        case (state_q)
            S_IDLE: begin
                if (bus.clr || clr_pend_q) begin
                    state_d    = S_CLR;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                end else if (bus.req) begin
                    addr_d  = bus.addr;
                    state_d = bus.rwn ? S_RD : S_WR;
                end
            end
            S_RD: begin
                rdata_d = mem_q[addr_q];
                state_d = S_DRV;
            end
            S_DRV: begin
                state_d = S_TURN;
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            S_WR: begin
                // Host holds write data on the bus for the whole WR cycle.
                mem_we_c = 1'b1;
                state_d  = S_IDLE;
            end
            S_CLR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q;
                mem_wdata_c = CLR_VAL;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A clear seen mid-transaction is remembered; one seen mid-sweep is dropped.
        if (bus.clr && (state_q != S_IDLE) && (state_q != S_CLR)) begin
            clr_pend_d = 1'b1;
        end

        ack_d      = (state_d == S_WR) || (state_d == S_DRV);
        drive_en_d = (state_d == S_DRV);
        busy_d     = (state_d != S_IDLE) || clr_pend_d;
    end

    // Control state and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            clr_pend_q <= 1'b0;
            ack_q      <= 1'b0;
            drive_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            clr_pend_q <= clr_pend_d;
            ack_q      <= ack_d;
            drive_en_q <= drive_en_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array and read data register; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
        rdata_q <= rdata_d;
    end

    assign data         = drive_en_q ? rdata_q : {DATA_W{1'bz}};
    assign bus.ack      = ack_q;
    assign bus.drive_en = drive_en_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_bus_ram_ctrl.sv
// Scoreboard bench for bus_ram_ctrl: default 8x256 instance plus a 16x16 instance.
module tb_bus_ram_ctrl;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t q1[$];
    exp_t q2[$];

    bus_ram_ctrl_if #(.ADDR_W(8)) bif ();
    bus_ram_ctrl_if #(.ADDR_W(4)) bif2 ();

    wire  [7:0]  data1;
    logic        tb_drv1;
    logic [7:0]  tb_wdata1;
    wire  [15:0] data2;
    logic        tb_drv2;
    logic [15:0] tb_wdata2;

    assign data1 = tb_drv1 ? tb_wdata1 : 8'hzz;
    assign data2 = tb_drv2 ? tb_wdata2 : 16'hzzzz;

    bus_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .CLR_VAL(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .data(data1)
    );

    bus_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .CLR_VAL(16'hBEEF)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bif2), .data(data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input logic rd, input logic [15:0] v);
        exp_t e;
        e.is_rd = rd;
        e.val   = v;
        return e;
    endfunction

    function automatic void chk_out(input string tag, input logic a, input logic d, input logic b);
        check({tag, "_ack"}, 32'(bif.ack), 32'(a));
        check({tag, "_drive_en"}, 32'(bif.drive_en), 32'(d));
        check({tag, "_busy"}, 32'(bif.busy), 32'(b));
    endfunction

    // Scoreboard monitor for the 8-bit instance: every ack pops one expectation.
    logic prev_ack1;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack1 <= 1'b0;
        end else begin
            if (bif.ack) begin
                check("ack_one_cycle", 32'(prev_ack1), 32'd0);
                if (q1.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    check("ack_kind", 32'(bif.drive_en), 32'(q1[0].is_rd));
                    if (q1[0].is_rd) check("rd_data", 32'(data1), 32'(q1[0].val));
                    void'(q1.pop_front());
                end
            end
            if (bif.drive_en) check("drive_implies_ack", 32'(bif.ack), 32'd1);
            prev_ack1 <= bif.ack;
        end
    end

    // Scoreboard monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (rst_n && bif2.ack) begin
            if (q2.size() == 0) begin
                check("p_unexpected_ack", 32'd1, 32'd0);
            end else begin
                check("p_ack_kind", 32'(bif2.drive_en), 32'(q2[0].is_rd));
                if (q2[0].is_rd) check("p_rd_data", 32'(data2), 32'(q2[0].val));
                void'(q2.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bif.busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (bif.busy) check("idle_timeout", 32'(bif.busy), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] v, input bit chk);
        wait_idle();
        tick();
        bif.req = 1'b1; bif.rwn = 1'b0; bif.addr = a;
        tb_drv1 = 1'b1; tb_wdata1 = v;
        q1.push_back(mk(1'b0, 16'(v)));
        @(posedge clk);
        #2 bif.req = 1'b0;
        @(negedge clk);
        if (chk) chk_out("wr_c1", 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2 tb_drv1 = 1'b0;
        @(negedge clk);
        if (chk) chk_out("wr_c2", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] v, input bit chk);
        wait_idle();
        tick();
        bif.req = 1'b1; bif.rwn = 1'b1; bif.addr = a;
        q1.push_back(mk(1'b1, 16'(v)));
        @(posedge clk);
        #2 bif.req = 1'b0;
        @(negedge clk);
        if (chk) chk_out("rd_c1", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (chk) chk_out("rd_c2", 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (chk) chk_out("rd_c3", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (chk) chk_out("rd_c4", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        bif.req = 1'b0; bif.rwn = 1'b0; bif.addr = '0; bif.clr = 1'b0;
        bif2.req = 1'b0; bif2.rwn = 1'b0; bif2.addr = '0; bif2.clr = 1'b0;
        tb_drv1 = 1'b0; tb_wdata1 = '0; tb_drv2 = 1'b0; tb_wdata2 = '0;
        #3;
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        check("reset_p_busy", 32'(bif2.busy), 32'd0);
        #20 rst_n = 1'b1;

        // Write then read with cycle-accurate output checks.
        do_write(8'h10, 8'hA5, 1'b1);
        do_read(8'h10, 8'hA5, 1'b1);

        // Back-to-back: req held high, write then read of the same word.
        wait_idle();
        tick();
        bif.req = 1'b1; bif.rwn = 1'b0; bif.addr = 8'h01;
        tb_drv1 = 1'b1; tb_wdata1 = 8'h3C;
        q1.push_back(mk(1'b0, 16'h003C));
        q1.push_back(mk(1'b1, 16'h003C));
        @(posedge clk);
        #2 bif.rwn = 1'b1;
        @(posedge clk);
        #2 tb_drv1 = 1'b0;
        @(negedge clk);
        chk_out("b2b_idle", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 bif.req = 1'b0;
        @(negedge clk);
        chk_out("b2b_rd", 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;

        // Clear sweep with a read request raised partway through.
        do_write(8'h00, 8'hFF, 1'b0);
        do_write(8'h7F, 8'hFF, 1'b0);
        do_write(8'hFF, 8'hFF, 1'b0);
        wait_idle();
        tick();
        bif.clr = 1'b1;
        @(posedge clk);
        #2 bif.clr = 1'b0;
        n = 0; acks = 0;
        @(negedge clk);
        while (bif.busy && n < 400) begin
            n++;
            if (bif.ack) acks++;
            if (n == 100) begin
                bif.req = 1'b1; bif.rwn = 1'b1; bif.addr = 8'h7F;
                q1.push_back(mk(1'b1, 16'h0000));
            end
            @(negedge clk);
        end
        check("clr_busy_cycles", 32'(n), 32'd256);
        check("clr_no_ack_in_sweep", 32'(acks), 32'd0);
        @(posedge clk);
        #2 bif.req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        do_read(8'h00, 8'h00, 1'b0);
        do_read(8'hFF, 8'h00, 1'b0);

        // Clear pulsed during DRV becomes pending; a simultaneous req waits for the sweep.
        do_write(8'h42, 8'h5A, 1'b0);
        wait_idle();
        tick();
        bif.req = 1'b1; bif.rwn = 1'b1; bif.addr = 8'h42;
        q1.push_back(mk(1'b1, 16'h005A));
        @(posedge clk);
        #2 bif.req = 1'b0;
        @(posedge clk);
        #2;
        bif.clr = 1'b1;
        bif.req = 1'b1; bif.rwn = 1'b1; bif.addr = 8'h42;
        q1.push_back(mk(1'b1, 16'h0000));
        @(negedge clk);
        check("pc_drv", 32'(bif.drive_en), 32'd1);
        @(posedge clk);
        #2 bif.clr = 1'b0;
        @(negedge clk);
        chk_out("pc_turn", 1'b0, 1'b0, 1'b1);
        n = 0;
        @(posedge clk);
        @(negedge clk);
        while (bif.busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("pc_busy_cycles", 32'(n), 32'd257);
        @(posedge clk);
        #2 bif.req = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        // Async reset during DRV releases the bus without a clock edge.
        do_write(8'h33, 8'h77, 1'b0);
        wait_idle();
        tick();
        bif.req = 1'b1; bif.rwn = 1'b1; bif.addr = 8'h33;
        q1.push_back(mk(1'b1, 16'h0077));
        @(posedge clk);
        #2 bif.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        do_read(8'h33, 8'h77, 1'b1);

        // Parameterised instance: 16-bit words, 16 entries, clear value BEEF.
        tick();
        bif2.req = 1'b1; bif2.rwn = 1'b0; bif2.addr = 4'hF;
        tb_drv2 = 1'b1; tb_wdata2 = 16'h1234;
        q2.push_back(mk(1'b0, 16'h1234));
        @(posedge clk);
        #2 bif2.req = 1'b0;
        @(posedge clk);
        #2 tb_drv2 = 1'b0;
        tick();
        bif2.req = 1'b1; bif2.rwn = 1'b1; bif2.addr = 4'hF;
        q2.push_back(mk(1'b1, 16'h1234));
        @(posedge clk);
        #2 bif2.req = 1'b0;
        repeat (3) @(posedge clk);
        #2 bif2.clr = 1'b1;
        @(posedge clk);
        #2 bif2.clr = 1'b0;
        n = 0;
        @(negedge clk);
        while (bif2.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("p_clr_cycles", 32'(n), 32'd16);
        tick();
        bif2.req = 1'b1; bif2.rwn = 1'b1; bif2.addr = 4'hF;
        q2.push_back(mk(1'b1, 16'hBEEF));
        @(posedge clk);
        #2 bif2.req = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        check("sb1_drained", 32'(q1.size()), 32'd0);
        check("sb2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
